fetch_queue: RTL and testbench

In-order instruction fetch queue at the consumer end of the stage1 fetch path. It pairs each fetch address issued to the instruction cache with the instruction word that comes back, and holds up to DEPTH in-flight fetches. It delivers {pc, inst} pairs to decode under a valid/ready handshake. On a redirect it discards all queued and in-flight fetches.

---
 rtl/fetch_queue_pkg.sv | 29 ++
 rtl/ifq_ptr.sv | 44 ++++
 rtl/fetch_queue.sv | 175 +++++++++++++++++
 tb/tb_fetch_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue_pkg
// Brief   : Shared types for the fetch queue plus the reset-PC / NOP encodings
//           also used by the PC and decode stages.
// Revision: 1.0
// ============================================================================

`ifndef PC_RESET
`define PC_RESET 32'h8000_0000
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif

package fetch_queue_pkg;

    localparam int c_XLEN = 32;

    typedef logic [c_XLEN-1:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t inst;
    } ifq_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifq_ptr.sv
`default_nettype none
// ============================================================================
// Module  : ifq_ptr
// Brief   : Wrap-around pointer register with increment and synchronous clear.
// Revision: 1.0
// ============================================================================

module ifq_ptr #(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (clr) begin
            w_ptr_nxt = '0;
        end else if (inc) begin
            // explicit wrap keeps the register correct even for a non-power-of-two DEPTH
            w_ptr_nxt = (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Brief   : In-order fetch queue pairing icache requests with their returned
//           instruction words; defining IFQ_PERF_EN adds drop/stall counters.
// Revision: 1.0
// ============================================================================

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_inst,
    input  logic        flush,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0] perf_drop_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] w_head;
    logic [c_PTR_W-1:0] w_tail;
    logic [c_PTR_W-1:0] w_fill_ptr;

    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_drop_cnt;
    ifq_entry_t         r_entry [DEPTH];
    logic [DEPTH-1:0]   r_filled;

    logic               w_push;
    logic               w_pop;
    logic               w_fill;
    logic               w_dropping;
    logic               w_discard;
    logic [c_CNT_W-1:0] w_filled_cnt;
    logic [c_CNT_W-1:0] w_unfilled;

    assign req_ready  = (r_count < c_DEPTH) && !flush;
    assign out_valid  = (r_count != '0) && r_filled[w_head];
    assign out_pc     = r_entry[w_head].pc;
    assign out_inst   = r_entry[w_head].inst;

    assign w_dropping = (r_drop_cnt != '0);
    assign w_push     = req_valid && req_ready;
    assign w_pop      = !flush && out_valid && out_ready;
    assign w_fill     = !flush && resp_valid && !w_dropping;
    assign w_discard  = resp_valid && (flush || w_dropping);

    // Live entries are the only ones with filled set, so the gap is the in-flight count.
    always_comb begin
        w_filled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_filled_cnt = w_filled_cnt + c_CNT_W'(r_filled[i]);
        end
    end

    assign w_unfilled = r_count - w_filled_cnt;

    ifq_ptr #(.DEPTH(DEPTH)) u_head_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (w_pop),
        .ptr   (w_head)
    );

    ifq_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (w_push),
        .ptr   (w_tail)
    );

    ifq_ptr #(.DEPTH(DEPTH)) u_fill_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (w_fill),
        .ptr   (w_fill_ptr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A response arriving in the flush cycle retires one of the fetches being killed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_drop_cnt <= r_drop_cnt + w_unfilled - c_CNT_W'(resp_valid);
        end else if (resp_valid && w_dropping) begin
            r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i].pc   <= `PC_RESET;
                r_entry[i].inst <= `INSTR_NOP;
            end
            r_filled <= '0;
        end else if (flush) begin
            r_filled <= '0;
        end else begin
            if (w_push) begin
                r_entry[w_tail].pc <= req_pc;
                r_filled[w_tail]   <= 1'b0;
            end
            if (w_fill) begin
                r_entry[w_fill_ptr].inst <= resp_inst;
                r_filled[w_fill_ptr]     <= 1'b1;
            end
            if (w_pop) begin
                r_filled[w_head] <= 1'b0;
            end
        end
    end

`ifdef IFQ_PERF_EN
    logic [31:0] r_perf_drop_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_drop_cnt  <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_discard) begin
                r_perf_drop_cnt <= r_perf_drop_cnt + 32'd1;
            end
            if (out_valid && !out_ready) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_drop_cnt  = r_perf_drop_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`else
    logic w_unused_discard;
    assign w_unused_discard = w_discard;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_queue
// Brief   : Self-checking bench for fetch_queue against a queue-based model.
// Revision: 1.0
// ============================================================================

`ifndef PC_RESET
`define PC_RESET 32'h8000_0000
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif

module tb_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
`ifdef IFQ_PERF_EN
    logic [31:0] perf_drop_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_pc         (req_pc),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_inst      (resp_inst),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_ready      (out_ready)
`ifdef IFQ_PERF_EN
        ,
        .perf_drop_cnt  (perf_drop_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: PCs of live entries in order, and instruction words of those filled so far.
    logic [31:0] m_pc_q[$];
    logic [31:0] m_inst_q[$];
    int          m_drop;
    int          ic_out;
    int          popped;
    logic [31:0] m_pdrop;
    logic [31:0] m_pstall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc_q.delete();
        m_inst_q.delete();
        m_drop   = 0;
        ic_out   = 0;
        m_pdrop  = '0;
        m_pstall = '0;
    endtask

    task automatic drive_idle();
        req_valid  = 1'b0;
        req_pc     = '0;
        resp_valid = 1'b0;
        resp_inst  = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;
    endtask

    // One clock: drive, compare at the falling edge, then advance the model at the rising edge.
    task automatic cycle(input string ph, input bit rv, input logic [31:0] pc, input bit rsp,
                         input logic [31:0] inst, input bit fl, input bit ordy);
        bit exp_ready;
        bit exp_valid;
        bit push;
        bit pop;
        bit discard;
        req_valid  = rv;
        req_pc     = pc;
        resp_valid = rsp;
        resp_inst  = inst;
        flush      = fl;
        out_ready  = ordy;
        exp_ready  = (m_pc_q.size() < DEPTH) && !fl;
        exp_valid  = (m_inst_q.size() > 0);
        @(negedge clk);
        check({ph, ".req_ready"}, 32'(req_ready), 32'(exp_ready));
        check({ph, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check({ph, ".out_pc"}, out_pc, m_pc_q[0]);
            check({ph, ".out_inst"}, out_inst, m_inst_q[0]);
        end
`ifdef IFQ_PERF_EN
        check({ph, ".perf_drop"}, perf_drop_cnt, m_pdrop);
        check({ph, ".perf_stall"}, perf_stall_cnt, m_pstall);
`endif
        push    = rv && exp_ready;
        pop     = !fl && exp_valid && ordy;
        discard = rsp && (fl || m_drop > 0);
        @(posedge clk);
        if (fl) begin
            m_drop = m_drop + (m_pc_q.size() - m_inst_q.size()) - int'(rsp);
            m_pc_q.delete();
            m_inst_q.delete();
        end else begin
            if (rsp) begin
                if (m_drop > 0) m_drop--;
                else m_inst_q.push_back(inst);
            end
            if (pop) begin
                void'(m_pc_q.pop_front());
                void'(m_inst_q.pop_front());
                popped++;
            end
            if (push) m_pc_q.push_back(pc);
        end
        ic_out = ic_out + int'(push) - int'(rsp);
        if (discard) m_pdrop = m_pdrop + 32'd1;
        if (exp_valid && !ordy) m_pstall = m_pstall + 32'd1;
        #1;
    endtask

    task automatic check_reset_state(input string ph);
        check({ph, ".out_valid"}, 32'(out_valid), 32'd0);
        check({ph, ".req_ready"}, 32'(req_ready), 32'd1);
        check({ph, ".out_pc"}, out_pc, `PC_RESET);
        check({ph, ".out_inst"}, out_inst, `INSTR_NOP);
`ifdef IFQ_PERF_EN
        check({ph, ".perf_drop"}, perf_drop_cnt, 32'd0);
        check({ph, ".perf_stall"}, perf_stall_cnt, 32'd0);
`endif
    endtask

    task automatic run_wrap();
        int nxt;
        int start;
        bit rv;
        bit acc;
        nxt   = 0;
        start = popped;
        for (int b = 0; b < 80 && (popped - start) < 10; b++) begin
            rv  = (nxt < 10);
            acc = rv && (m_pc_q.size() < DEPTH);
            cycle("wrap", rv, 32'(nxt * 4), ic_out > 0, $urandom, 1'b0, (b % 2) == 1);
            if (acc) nxt++;
        end
        check("wrap.popped", 32'(popped - start), 32'd10);
    endtask

    task automatic run_random(input int n);
        bit rsp;
        bit fl;
        for (int i = 0; i < n; i++) begin
            rsp = (ic_out > 0) && ($urandom_range(0, 1) == 1);
            fl  = ($urandom_range(0, 19) == 0) && ((ic_out - int'(rsp)) <= DEPTH);
            cycle("rand", $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, rsp,
                  $urandom, fl, $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        popped = 0;
        model_reset();
        drive_idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b1;

        // single fetch with a response two cycles after the request
        cycle("single", 1, 32'h0000_2000, 0, 0, 0, 1);
        cycle("single", 0, 0, 0, 0, 0, 1);
        cycle("single", 0, 0, 1, 32'h0000_0013, 0, 1);
        cycle("single", 0, 0, 0, 0, 0, 1);
        cycle("single", 0, 0, 0, 0, 0, 1);

        // fill while decode stalls, then drain
        cycle("stall", 1, 32'h10, 0, 0, 0, 0);
        cycle("stall", 1, 32'h14, 1, 32'hAAAA_0001, 0, 0);
        cycle("stall", 0, 0, 1, 32'hAAAA_0002, 0, 0);
        for (int i = 0; i < 5; i++) cycle("stall", 1, 32'h18, 0, 0, 0, 0);
        cycle("stall", 0, 0, 0, 0, 0, 1);
        cycle("stall", 0, 0, 0, 0, 0, 1);
        cycle("stall", 0, 0, 0, 0, 0, 1);

        // flush with two fetches in flight; their responses must vanish
        cycle("flush2", 1, 32'h10, 0, 0, 0, 1);
        cycle("flush2", 1, 32'h14, 0, 0, 0, 1);
        cycle("flush2", 1, 32'h18, 0, 0, 1, 1);
        cycle("flush2", 0, 0, 1, 32'hDEAD_0001, 0, 1);
        cycle("flush2", 0, 0, 1, 32'hDEAD_0002, 0, 1);
        cycle("flush2", 1, 32'h80, 0, 0, 0, 1);
        cycle("flush2", 0, 0, 1, 32'hBEEF_0080, 0, 0);
        cycle("flush2", 0, 0, 0, 0, 0, 1);
        cycle("flush2", 0, 0, 0, 0, 0, 1);

        // flush in the same cycle as the one outstanding response
        cycle("flushr", 1, 32'h40, 0, 0, 0, 1);
        cycle("flushr", 0, 0, 1, 32'hDEAD_0040, 1, 1);
        cycle("flushr", 0, 0, 0, 0, 0, 1);
        cycle("flushr", 1, 32'h44, 0, 0, 0, 1);
        cycle("flushr", 0, 0, 1, 32'hC0DE_0044, 0, 0);
        cycle("flushr", 0, 0, 0, 0, 0, 1);
        cycle("flushr", 0, 0, 0, 0, 0, 1);

        run_wrap();

        // asynchronous reset while two filled entries are held
        cycle("areset", 1, 32'h100, 0, 0, 0, 0);
        cycle("areset", 1, 32'h104, 1, 32'h1111_0100, 0, 0);
        cycle("areset", 0, 0, 1, 32'h1111_0104, 0, 0);
        cycle("areset", 0, 0, 0, 0, 0, 0);
        drive_idle();
        reset = 1'b0;
        #2;
        check_reset_state("areset");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_random(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
